// File: rtl/bcd_scan_pkg.sv
// Shared definitions for the BCD scan driver: digit count, saturation limit,
// converter state type and the double-dabble nibble correction.
package bcd_scan_pkg;

   localparam int NDIG    = 4;
   localparam int MAX_VAL = 9999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      LATCH = 2'd2
   } conv_state_e;

   // A BCD nibble of 5 or more would overflow past 9 when doubled, so it is
   // pre-corrected by +3 before the shift.
   function automatic logic [3:0] nibbleAdjust(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. A start in IDLE captures a
// saturated operand, CONV runs one shift per cycle for DW cycles, and LATCH
// marks the single cycle in which the finished BCD value is valid on bcd.
module bin2bcd_seq
   import bcd_scan_pkg::*;
#(
   parameter int DW = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] bin,
   output logic [15:0]   bcd,
   output logic          busy,
   output logic          ovf,
   output logic          done
);

   localparam int            CW   = $clog2(DW) + 1;
   localparam logic [DW-1:0] MAXV = DW'(MAX_VAL);
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   conv_state_e   state_q, state_d;
   logic [DW-1:0] bin_q, bin_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [CW-1:0] shiftCnt_q, shiftCnt_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   bcdAdj;

   // Next-state logic: accept a start only when idle, then one add-3/shift per CONV cycle.
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      shiftCnt_d = shiftCnt_q;
      ovf_d      = ovf_q;
      bcdAdj     = '0;
      for (int k = 0; k < NDIG; k++) begin
         bcdAdj[4*k +: 4] = nibbleAdjust(bcd_q[4*k +: 4]);
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = CONV;
               bcd_d      = '0;
               shiftCnt_d = '0;
               ovf_d      = (bin > MAXV);
               bin_d      = (bin > MAXV) ? MAXV : bin;
            end
         end
         CONV: begin
            {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
            shiftCnt_d     = shiftCnt_q + 1'b1;
            if (shiftCnt_q == LAST) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Converter registers; reset abandons any conversion in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         shiftCnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         shiftCnt_q <= shiftCnt_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bcd  = bcd_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == LATCH);
   assign ovf  = ovf_q;

endmodule

// File: rtl/bcd_scan_driver.sv
// Binary-to-4-digit BCD display driver: converts a loaded value, holds the
// result and time-multiplexes one digit per SCAN_DIV-cycle slot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero positions (units
// digit always shown).
module bcd_scan_driver
   import bcd_scan_pkg::*;
#(
   parameter int DW       = 14,
   parameter int SCAN_DIV = 50000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] bin_in,
   input  logic          load,
   output logic          busy,
   output logic          ovf,
   output logic [3:0]    digit,
   output logic [3:0]    sel
);

   localparam int            PW       = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam int            IW       = $clog2(NDIG);

   logic [PW-1:0] prescale_q, prescale_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [15:0]   disp_q, disp_d;
   logic [15:0]   convBcd;
   logic          convDone;

   bin2bcd_seq #(
      .DW(DW)
   ) u_conv (
      .clk  (clk),
      .rst_n(rst_n),
      .start(load),
      .bin  (bin_in),
      .bcd  (convBcd),
      .busy (busy),
      .ovf  (ovf),
      .done (convDone)
   );

   // Free-running prescaler steps the scan index on wrap; the display only takes finished results.
   always_comb begin
      prescale_d = prescale_q + 1'b1;
      idx_d      = idx_q;
      disp_d     = disp_q;
      if (prescale_q == PRE_LAST) begin
         prescale_d = '0;
         idx_d      = idx_q + 1'b1;
      end
      if (convDone) begin
         disp_d = convBcd;
      end
   end

   // Scan and display registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q <= '0;
         idx_q      <= '0;
         disp_q     <= '0;
      end else begin
         prescale_q <= prescale_d;
         idx_q      <= idx_d;
         disp_q     <= disp_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NDIG-1:0] zeroNib;
   logic            blank;

   // Select the current digit; a slot is dark when it and every more significant digit are zero.
   always_comb begin
      zeroNib = '0;
      for (int k = 0; k < NDIG; k++) begin
         zeroNib[k] = (disp_q[4*k +: 4] == 4'd0);
      end
      blank = (idx_q != '0) && ((zeroNib >> idx_q) == (4'b1111 >> idx_q));
      digit = disp_q[{idx_q, 2'b00} +: 4];
      sel   = blank ? 4'b1111 : ~(4'b0001 << idx_q);
   end
`else
   // Select the current digit and drive its active-low enable.
   always_comb begin
      digit = disp_q[{idx_q, 2'b00} +: 4];
      sel   = ~(4'b0001 << idx_q);
   end
`endif

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver with SCAN_DIV=4. A behavioural model
// tracks the displayed value and scan slot arithmetically; literal frame checks
// pin known values. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_scan_driver;

   localparam int DW          = 14;
   localparam int SCAN_DIV    = 4;
   localparam int BUSY_CYCLES = DW + 1;
`ifdef LEADING_ZERO_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          load   = 1'b0;
   logic [DW-1:0] bin_in = '0;
   logic          busy;
   logic          ovf;
   logic [3:0]    digit;
   logic [3:0]    sel;

   int checks   = 0;
   int failures = 0;

   int mEdges    = 0;
   int mBusyLeft = 0;
   int mDisp     = 0;
   int mPend     = 0;
   int mOvf      = 0;
   int cmpSlot;

   always #5 clk = ~clk;

   bcd_scan_driver #(
      .DW      (DW),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bin_in(bin_in),
      .load  (load),
      .busy  (busy),
      .ovf   (ovf),
      .digit (digit),
      .sel   (sel)
   );

   function automatic int pow10(input int p);
      int r = 1;
      for (int i = 0; i < p; i++) r = r * 10;
      return r;
   endfunction

   function automatic int decDigit(input int v, input int pos);
      return (v / pow10(pos)) % 10;
   endfunction

   function automatic int expSel(input int v, input int slot);
      int s;
      s = 15 & ~(1 << slot);
      if (BLANK && slot > 0 && v < pow10(slot)) s = 15;
      return s;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: a load accepted while idle shows min(v,9999) after BUSY_CYCLES edges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mEdges    = 0;
         mBusyLeft = 0;
         mDisp     = 0;
         mPend     = 0;
         mOvf      = 0;
      end else begin
         mEdges++;
         if (mBusyLeft > 0) begin
            mBusyLeft--;
            if (mBusyLeft == 0) mDisp = mPend;
         end else if (load) begin
            mBusyLeft = BUSY_CYCLES;
            mPend     = (int'(bin_in) > 9999) ? 9999 : int'(bin_in);
            mOvf      = (int'(bin_in) > 9999) ? 1 : 0;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      cmpSlot = (mEdges / SCAN_DIV) % 4;
      checkOutput("busy", int'(busy), (mBusyLeft > 0) ? 1 : 0);
      checkOutput("ovf", int'(ovf), mOvf);
      checkOutput("digit", int'(digit), decDigit(mDisp, cmpSlot));
      checkOutput("sel", int'(sel), expSel(mDisp, cmpSlot));
   end

   task automatic applyStimulus(input logic [DW-1:0] v);
      @(negedge clk);
      bin_in = v;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 64) begin
         @(negedge clk);
         n++;
      end
      checkOutput("waitIdle", int'(busy), 0);
   endtask

   // Counts busy cycles from the current negedge, optionally pulsing a load on busy cycle 3.
   task automatic measureBusy(input bit inject, input logic [DW-1:0] injVal, output int n);
      n = 0;
      for (int c = 0; c < 64; c++) begin
         if (!busy) break;
         n++;
         if (inject && n == 3) begin
            bin_in = injVal;
            load   = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
   endtask

   // Walks one full frame comparing against literal digits (d3 = thousands).
   task automatic checkOutputFrame(input string name, input int d3, input int d2,
                                   input int d1, input int d0, input int ovfExp);
      int lit[4];
      int slot;
      int s;
      bit allZero;
      lit[0] = d0;
      lit[1] = d1;
      lit[2] = d2;
      lit[3] = d3;
      checkOutput({name, "_ovf"}, int'(ovf), ovfExp);
      for (int c = 0; c < 4 * SCAN_DIV; c++) begin
         @(negedge clk);
         #1;
         slot = (mEdges / SCAN_DIV) % 4;
         s    = 15 & ~(1 << slot);
         allZero = 1'b1;
         for (int k = slot; k < 4; k++) if (lit[k] != 0) allZero = 1'b0;
         if (BLANK && slot > 0 && allZero) s = 15;
         checkOutput({name, "_digit"}, int'(digit), lit[slot]);
         checkOutput({name, "_sel"}, int'(sel), s);
      end
   endtask

   initial begin
      int n;
      int bnd[8];
      logic [DW-1:0] v;

      bnd = '{0, 9, 10, 99, 100, 999, 1000, 9999};

      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_sel", int'(sel), 14);
      checkOutput("rst_digit", int'(digit), 0);
      checkOutput("rst_busy", int'(busy), 0);
      #1 rst_n = 1'b1;

      checkOutputFrame("idle", 0, 0, 0, 0, 0);
      checkOutputFrame("idle2", 0, 0, 0, 0, 0);

      applyStimulus(14'd1234);
      measureBusy(1'b0, '0, n);
      checkOutput("busyLen1234", n, 15);
      checkOutputFrame("v1234", 1, 2, 3, 4, 0);

      applyStimulus(14'd12000);
      waitIdle();
      checkOutputFrame("sat12000", 9, 9, 9, 9, 1);

      applyStimulus(14'd7);
      waitIdle();
      checkOutputFrame("v7", 0, 0, 0, 7, 0);

      applyStimulus(14'd5678);
      measureBusy(1'b1, 14'd42, n);
      checkOutput("busyLen5678", n, 15);
      checkOutputFrame("v5678", 5, 6, 7, 8, 0);

      applyStimulus(14'd4321);
      repeat (8) @(negedge clk);
      checkOutput("busyBeforeRst", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRst_busy", int'(busy), 0);
      checkOutput("midRst_digit", int'(digit), 0);
      checkOutput("midRst_sel", int'(sel), 14);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      checkOutputFrame("afterRst", 0, 0, 0, 0, 0);
      checkOutputFrame("afterRst2", 0, 0, 0, 0, 0);

      foreach (bnd[i]) begin
         applyStimulus(DW'(bnd[i]));
         waitIdle();
         checkOutputFrame("bound", decDigit(bnd[i], 3), decDigit(bnd[i], 2),
                          decDigit(bnd[i], 1), decDigit(bnd[i], 0), 0);
      end

      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) v = DW'($urandom_range(10000, 16383));
         else                           v = DW'($urandom_range(0, 9999));
         applyStimulus(v);
         repeat ($urandom_range(0, 24)) @(negedge clk);
      end
      waitIdle();
      repeat (2 * 4 * SCAN_DIV) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
